pool_unit: RTL and testbench
============================

// Module: pool_unit
// PURPOSE
//  Parametrised 2x2/stride-2 pooling engine for the CNN accelerator datapath. Reads
//  W,H,D and a mode word from DRAM, then streams every 2x2 window of an arbitrary-size
//  ifmap (no power-of-2 packing) and writes one max or average result per window.
//  Supports signed/unsigned data and odd dimensions. Shares the single-port DRAM
//  model (1-cycle read latency) with the other layer engines.
// PARAMETERS
//  DATA_WIDTH  32      pixel word width
//  ADDR_WIDTH  18      DRAM word-address width
//  DIM_WIDTH   8       width of W/H/D fields and counters
//  PARAM_BASE  0       address of parameter block (W,H,D,MODE at +0..+3)
//  OFMAP_BASE  65536   ofmap base address
//  IFMAP_BASE  131072  ifmap base address
// PORTS
//  clk         in   1           clock
//  srstn       in   1           reset, synchronous, active-low
//  enable      in   1           start pulse; sampled only in IDLE
//  data_in     in   DATA_WIDTH  DRAM read data, valid 1 cycle after addr_in/dram_en_rd
//  addr_in     out  ADDR_WIDTH  DRAM read address (combinational from state/counters)
//  dram_en_rd  out  1           read strobe
//  data_out    out  DATA_WIDTH  write data (registered)
//  addr_out    out  ADDR_WIDTH  write address (registered)
//  dram_en_wr  out  1           write strobe (registered)
//  busy        out  1           high in every state except IDLE
//  done        out  1           one-cycle pulse on completion
// BEHAVIOUR
//  - Reset: state IDLE; data_out, addr_out=0; dram_en_wr, dram_en_rd, done, busy=0; all
//    counters/pointers 0. Reset mid-operation aborts immediately; no further writes.
//  - FSM: IDLE -enable-> LD_PARAM (4 reads, PARAM_BASE+0..3; data captured next cycle)
//    -> CALC (1 cycle: PS=W*H registered, OW=W>>1, OH=H>>1; if W<2|H<2|D==0 -> DONE)
//    -> POOL -> DRAIN (until final write issued) -> DONE (done=1, 1 cycle) -> IDLE.
//  - enable while busy ignored. MODE[0]: 0=max,1=avg. MODE[1]: 1=signed compare/sum.
//  - Ifmap element (x,y,z) at IFMAP_BASE+z*PS+y*W+x; window reads issued back-to-back
//    in order (x,y),(x+1,y),(x,y+1),(x+1,y+1); dram_en_rd=1 each cycle of POOL.
//  - Scan order x fastest (step 2), then y (step 2), then z. Odd W/H: last column/row
//    never read. Pointers incremental (no per-pixel multiply): base+=2; row end
//    base=row_base+2W; plane end base=plane_base+PS.
//  - Ofmap address = OFMAP_BASE + output index, index 0..OW*OH*D-1 incrementing by 1.
//  - Latency: 4th read address at cycle t -> data_out/addr_out/dram_en_wr valid at t+2,
//    write strobe 1 cycle. Throughput 1 result / 4 cycles, no bubbles between windows.
//  - Max: ties pick earlier element. Avg: (DATA_WIDTH+2)-bit sum, >>2 (arithmetic if
//    signed, logical if unsigned), i.e. floor; truncated to DATA_WIDTH.
//  - Addresses wrap modulo 2^ADDR_WIDTH; no range checking.
//  - DONE entered the cycle after the last write strobe.
// STRUCTURE
//  - Package pool_pkg: state enum (IDLE,LD_PARAM,CALC,POOL,DRAIN,DONE), base-address
//    constants, MODE bit indices, parameter-offset constants.
//  - Sub-module pool_reduce: 4-word collector + max/avg reduce, mode/signed inputs,
//    registered output; top holds FSM, counters, address generation, write pipeline.
// TESTING
//  - 4x4x1 unsigned max, ifmap=0..15 row-major -> writes 5,7,13,15 at 65536..65539.
//  - 2x2x1 signed avg {-1,-2,-3,-4} -> data_out=-3 (0xFFFFFFFD); unsigned max same ->
//    0xFFFFFFFF.
//  - 5x3x2 max -> exactly 4 writes (OW=2,OH=1,D=2); column 4 and row 2 never on addr_in;
//    plane 1 reads start at 131087.
//  - W=1 (or D=0) -> no POOL reads, no writes, done pulse within 7 cycles of enable.
//  - srstn low mid-POOL -> next cycle IDLE, all outputs 0; fresh enable reruns correctly.
//  - enable held high during run -> single run, one done pulse; busy low only in IDLE.

Source files
------------

// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2/stride-2 pooling engine.
package pool_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLdParam,
    StCalc,
    StPool,
    StDrain,
    StDone
  } pool_state_e;

  // Default DRAM map: parameter block, ofmap and ifmap regions.
  localparam int unsigned PARAM_BASE_DEF = 0;
  localparam int unsigned OFMAP_BASE_DEF = 65536;
  localparam int unsigned IFMAP_BASE_DEF = 131072;

  // Word offsets inside the parameter block.
  localparam logic [1:0] PARAM_OFS_W    = 2'd0;
  localparam logic [1:0] PARAM_OFS_H    = 2'd1;
  localparam logic [1:0] PARAM_OFS_D    = 2'd2;
  localparam logic [1:0] PARAM_OFS_MODE = 2'd3;

  // MODE word bit positions.
  localparam int unsigned MODE_AVG_BIT    = 0;
  localparam int unsigned MODE_SIGNED_BIT = 1;

endpackage

// File: rtl/pool_reduce.sv
// Collects the four words of a 2x2 window and reduces them to a max or floor-average.
// The fourth word is taken straight from the input so the result registers one cycle
// after it arrives.
module pool_reduce #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  i_valid,
  input  logic [1:0]            i_idx,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_avg,
  input  logic                  i_signed,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic                  o_valid
);

  logic [DATA_WIDTH-1:0] r_word [3];
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_valid;

  logic [DATA_WIDTH-1:0] w_win [4];
  logic [DATA_WIDTH-1:0] w_max;
  logic [DATA_WIDTH+1:0] w_sum;
  logic [DATA_WIDTH-1:0] w_avg;
  logic                  w_last;

  function automatic logic greater(input logic [DATA_WIDTH-1:0] a,
                                   input logic [DATA_WIDTH-1:0] b,
                                   input logic                  sgn);
    greater = sgn ? ($signed(a) > $signed(b)) : (a > b);
  endfunction

  assign w_last = i_valid && (i_idx == 2'd3);

  // Hold the first three window words.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      for (int i = 0; i < 3; i++) r_word[i] <= '0;
    end else if (i_valid && (i_idx != 2'd3)) begin
      r_word[i_idx] <= i_data;
    end
  end

  // Max (strictly greater replaces, so ties keep the earlier word) and widened sum.
  always_comb begin
    w_win[0] = r_word[0];
    w_win[1] = r_word[1];
    w_win[2] = r_word[2];
    w_win[3] = i_data;
    w_max    = w_win[0];
    w_sum    = '0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && greater(w_win[i], w_max, i_signed)) w_max = w_win[i];
      w_sum = w_sum + {{2{i_signed & w_win[i][DATA_WIDTH-1]}}, w_win[i]};
    end
    // Dropping the two LSBs is floor(sum/4) for either signedness once truncated.
    w_avg = w_sum[DATA_WIDTH+1:2];
  end

  // Register the reduced result and its strobe.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_result <= '0;
      r_valid  <= 1'b0;
    end else begin
      r_valid <= w_last;
      if (w_last) r_result <= i_avg ? w_avg : w_max;
    end
  end

  assign o_result = r_result;
  assign o_valid  = r_valid;

endmodule

// File: rtl/pool_unit.sv
// 2x2/stride-2 pooling engine: loads W/H/D/MODE from DRAM, streams every window of the
// ifmap with incremental pointers and writes one max/avg result per window.
module pool_unit
  import pool_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned DIM_WIDTH  = 8,
  parameter int unsigned PARAM_BASE = PARAM_BASE_DEF,
  parameter int unsigned OFMAP_BASE = OFMAP_BASE_DEF,
  parameter int unsigned IFMAP_BASE = IFMAP_BASE_DEF
) (
  input  logic                  clk,
  input  logic                  srstn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] addr_in,
  output logic                  dram_en_rd,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH-1:0] addr_out,
  output logic                  dram_en_wr,
  output logic                  busy,
  output logic                  done
);

  localparam logic [DIM_WIDTH-1:0]  DIM_ONE  = DIM_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_TWO = ADDR_WIDTH'(2);

  pool_state_e r_state, w_state_next;

  logic [1:0]            r_ld_cnt;
  logic [DIM_WIDTH-1:0]  r_w, r_h, r_d, r_ow, r_oh;
  logic [DIM_WIDTH-1:0]  r_x, r_y, r_z;
  logic                  r_avg, r_sgn;
  logic [ADDR_WIDTH-1:0] r_ps;
  logic [1:0]            r_ph;
  logic [ADDR_WIDTH-1:0] r_base, r_row_base, r_plane_base;
  logic                  r_rd_v;
  logic [1:0]            r_rd_ph;
  logic [ADDR_WIDTH-1:0] r_out_idx, r_addr_out;

  logic [1:0]            w_ld_ofs;
  logic [ADDR_WIDTH-1:0] w_w_ext, w_h_ext, w_w2;
  logic                  w_degenerate, w_win_end, w_last_win, w_res_last;
  logic                  w_wr_valid;
  logic [DATA_WIDTH-1:0] w_result;

  // Offset of the parameter word arriving on data_in (read issued last cycle).
  assign w_ld_ofs     = r_ld_cnt - 2'd1;
  assign w_w_ext      = ADDR_WIDTH'(r_w);
  assign w_h_ext      = ADDR_WIDTH'(r_h);
  assign w_w2         = {w_w_ext[ADDR_WIDTH-2:0], 1'b0};
  assign w_degenerate = (r_w < DIM_WIDTH'(2)) || (r_h < DIM_WIDTH'(2)) || (r_d == '0);
  assign w_win_end    = (r_ph == 2'd3);
  assign w_last_win   = (r_x == r_ow - DIM_ONE) && (r_y == r_oh - DIM_ONE) &&
                        (r_z == r_d - DIM_ONE);
  assign w_res_last   = r_rd_v && (r_rd_ph == 2'd3);

  // State register.
  always_ff @(posedge clk) begin
    if (!srstn) r_state <= StIdle;
    else        r_state <= w_state_next;
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (enable) w_state_next = StLdParam;
      StLdParam: if (r_ld_cnt == 2'd3) w_state_next = StCalc;
      StCalc:    w_state_next = w_degenerate ? StDone : StPool;
      StPool:    if (w_win_end && w_last_win) w_state_next = StDrain;
      // Only the final window's write can still be pending here.
      StDrain:   if (w_wr_valid) w_state_next = StDone;
      StDone:    w_state_next = StIdle;
      default:   w_state_next = StIdle;
    endcase
  end

  // FSM outputs: status flags and the combinational read port.
  always_comb begin
    busy       = (r_state != StIdle);
    done       = (r_state == StDone);
    dram_en_rd = 1'b0;
    addr_in    = '0;
    unique case (r_state)
      StLdParam: begin
        dram_en_rd = 1'b1;
        addr_in    = ADDR_WIDTH'(PARAM_BASE) + ADDR_WIDTH'(r_ld_cnt);
      end
      StPool: begin
        // Window order: (x,y), (x+1,y), (x,y+1), (x+1,y+1).
        dram_en_rd = 1'b1;
        addr_in    = r_base + (r_ph[0] ? ADDR_ONE : '0) + (r_ph[1] ? w_w_ext : '0);
      end
      default: ;
    endcase
  end

  // Parameter capture, dimension setup and incremental window pointers.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_ld_cnt     <= '0;
      r_w          <= '0;
      r_h          <= '0;
      r_d          <= '0;
      r_ow         <= '0;
      r_oh         <= '0;
      r_x          <= '0;
      r_y          <= '0;
      r_z          <= '0;
      r_avg        <= 1'b0;
      r_sgn        <= 1'b0;
      r_ps         <= '0;
      r_ph         <= '0;
      r_base       <= '0;
      r_row_base   <= '0;
      r_plane_base <= '0;
    end else begin
      unique case (r_state)
        StIdle: r_ld_cnt <= '0;
        StLdParam: begin
          r_ld_cnt <= r_ld_cnt + 2'd1;
          if (r_ld_cnt != 2'd0) begin
            case (w_ld_ofs)
              PARAM_OFS_W: r_w <= data_in[DIM_WIDTH-1:0];
              PARAM_OFS_H: r_h <= data_in[DIM_WIDTH-1:0];
              PARAM_OFS_D: r_d <= data_in[DIM_WIDTH-1:0];
              default: ;
            endcase
          end
        end
        StCalc: begin
          // The MODE word (last parameter read) arrives during this cycle.
          r_avg        <= data_in[MODE_AVG_BIT];
          r_sgn        <= data_in[MODE_SIGNED_BIT];
          r_ps         <= w_w_ext * w_h_ext;
          r_ow         <= r_w >> 1;
          r_oh         <= r_h >> 1;
          r_x          <= '0;
          r_y          <= '0;
          r_z          <= '0;
          r_ph         <= '0;
          r_base       <= ADDR_WIDTH'(IFMAP_BASE);
          r_row_base   <= ADDR_WIDTH'(IFMAP_BASE);
          r_plane_base <= ADDR_WIDTH'(IFMAP_BASE);
        end
        StPool: begin
          r_ph <= r_ph + 2'd1;
          if (w_win_end) begin
            if (r_x == r_ow - DIM_ONE) begin
              r_x <= '0;
              if (r_y == r_oh - DIM_ONE) begin
                r_y          <= '0;
                r_z          <= r_z + DIM_ONE;
                r_plane_base <= r_plane_base + r_ps;
                r_row_base   <= r_plane_base + r_ps;
                r_base       <= r_plane_base + r_ps;
              end else begin
                r_y        <= r_y + DIM_ONE;
                r_row_base <= r_row_base + w_w2;
                r_base     <= r_row_base + w_w2;
              end
            end else begin
              r_x    <= r_x + DIM_ONE;
              r_base <= r_base + ADDR_TWO;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Read-return tagging and ofmap address generation for the write pipeline.
  always_ff @(posedge clk) begin
    if (!srstn) begin
      r_rd_v     <= 1'b0;
      r_rd_ph    <= '0;
      r_out_idx  <= '0;
      r_addr_out <= '0;
    end else begin
      r_rd_v  <= (r_state == StPool);
      r_rd_ph <= r_ph;
      if (r_state == StCalc) begin
        r_out_idx <= '0;
      end else if (w_res_last) begin
        r_addr_out <= ADDR_WIDTH'(OFMAP_BASE) + r_out_idx;
        r_out_idx  <= r_out_idx + ADDR_ONE;
      end
    end
  end

  pool_reduce #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reduce (
    .clk      (clk),
    .srstn    (srstn),
    .i_valid  (r_rd_v),
    .i_idx    (r_rd_ph),
    .i_data   (data_in),
    .i_avg    (r_avg),
    .i_signed (r_sgn),
    .o_result (w_result),
    .o_valid  (w_wr_valid)
  );

  assign data_out   = w_result;
  assign addr_out   = r_addr_out;
  assign dram_en_wr = w_wr_valid;

endmodule

// File: tb/tb_pool_unit.sv
// Self-checking bench for pool_unit: DRAM model, window-level reference model and a
// per-cycle compare process, plus literal expectations for the hand-worked cases.
module tb_pool_unit;

  localparam int IFB = 131072;
  localparam int OFB = 65536;

  logic        clk = 1'b0;
  logic        srstn = 1'b0;
  logic        enable = 1'b0;
  logic [31:0] data_in = '0;
  logic [17:0] addr_in, addr_out;
  logic [31:0] data_out;
  logic        dram_en_rd, dram_en_wr, busy, done;

  always #5 clk = ~clk;

  pool_unit dut (
    .clk        (clk),
    .srstn      (srstn),
    .enable     (enable),
    .data_in    (data_in),
    .addr_in    (addr_in),
    .dram_en_rd (dram_en_rd),
    .data_out   (data_out),
    .addr_out   (addr_out),
    .dram_en_wr (dram_en_wr),
    .busy       (busy),
    .done       (done)
  );

  logic [31:0] mem [0:262143];

  // DRAM with one cycle of read latency.
  always @(posedge clk) data_in <= mem[addr_in];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
  endtask

  task automatic unexpected(input string name, input longint act);
    n_chk++;
    $display("FAIL %s: got activity at 0x%0h, required none", name, act);
  endtask

  // Expected traffic and observed logs.
  logic [17:0] exp_rd[$];
  logic [17:0] exp_wa[$];
  logic [31:0] exp_wd[$];
  int          exp_wc[$];
  logic [17:0] rd_log[$];
  logic [17:0] wa_log[$];
  logic [31:0] wd_log[$];
  int          rd_n = 0;
  int          done_cnt = 0;
  int          last_wr_cyc = 0;

  function automatic logic [31:0] ref_reduce(input logic [31:0] v[4], input logic [31:0] mode);
    logic   sgn;
    longint s;
    logic [31:0] best;
    logic   g;
    sgn = mode[1];
    if (mode[0]) begin
      s = 0;
      for (int k = 0; k < 4; k++) s += sgn ? longint'($signed(v[k])) : longint'(v[k]);
      s = s >>> 2;
      return s[31:0];
    end
    best = v[0];
    for (int k = 1; k < 4; k++) begin
      g = sgn ? ($signed(v[k]) > $signed(best)) : (v[k] > best);
      if (g) best = v[k];
    end
    return best;
  endfunction

  task automatic build_model(input int w, input int h, input int d, input logic [31:0] mode);
    int ps, idx, a;
    logic [31:0] v[4];
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete(); exp_wc.delete();
    for (int i = 0; i < 4; i++) exp_rd.push_back(18'(i));
    if (w < 2 || h < 2 || d == 0) return;
    ps = w * h;
    idx = 0;
    for (int z = 0; z < d; z++)
      for (int oy = 0; oy < h / 2; oy++)
        for (int ox = 0; ox < w / 2; ox++) begin
          for (int k = 0; k < 4; k++) begin
            a = IFB + z * ps + (2 * oy + k / 2) * w + 2 * ox + k % 2;
            exp_rd.push_back(a[17:0]);
            v[k] = mem[a[17:0]];
          end
          a = OFB + idx;
          exp_wa.push_back(a[17:0]);
          exp_wd.push_back(ref_reduce(v, mode));
          idx++;
        end
  endtask

  task automatic clear_logs();
    rd_log.delete(); wa_log.delete(); wd_log.delete(); exp_wc.delete();
    rd_n = 0;
    done_cnt = 0;
  endtask

  // Every-cycle comparison of DRAM traffic against the model.
  logic [31:0] cmp_e;
  int          cmp_c;
  always @(negedge clk) begin
    if (srstn) begin
      if (dram_en_rd) begin
        if (exp_rd.size() == 0) unexpected("rd_unexpected", addr_in);
        else begin
          cmp_e = 32'(exp_rd.pop_front());
          check("rd_addr", addr_in, cmp_e);
        end
        rd_n++;
        rd_log.push_back(addr_in);
        if (rd_n > 4 && (rd_n % 4) == 0) exp_wc.push_back(cyc + 2);
      end
      if (dram_en_wr) begin
        if (exp_wa.size() == 0) unexpected("wr_unexpected", addr_out);
        else begin
          cmp_e = 32'(exp_wa.pop_front());
          check("wr_addr", addr_out, cmp_e);
          cmp_e = exp_wd.pop_front();
          check("wr_data", data_out, cmp_e);
          cmp_c = (exp_wc.size() != 0) ? exp_wc.pop_front() : -1;
          check("wr_cycle", cyc, cmp_c);
        end
        wa_log.push_back(addr_out);
        wd_log.push_back(data_out);
        last_wr_cyc = cyc;
      end
      if (done) done_cnt++;
    end
  end

  task automatic set_params(input int w, input int h, input int d, input logic [31:0] mode);
    mem[0] = 32'(w);
    mem[1] = 32'(h);
    mem[2] = 32'(d);
    mem[3] = mode;
  endtask

  task automatic run(input string tag, input int w, input int h, input int d,
                     input logic [31:0] mode, input bit hold);
    int c0, dc, nexp, busy_drop;
    bit got;
    set_params(w, h, d, mode);
    build_model(w, h, d, mode);
    clear_logs();
    nexp = exp_wa.size();
    busy_drop = 0;
    got = 1'b0;
    dc = 0;
    @(negedge clk);
    enable = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!hold) enable = 1'b0;
      if (done) begin
        got = 1'b1;
        dc = cyc;
        break;
      end
      if (!busy) busy_drop++;
    end
    enable = 1'b0;
    check({tag, "_done_seen"}, got, 1);
    @(negedge clk);
    check({tag, "_idle_after_done"}, busy, 0);
    repeat (6) @(negedge clk);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_reads_left"}, exp_rd.size(), 0);
    check({tag, "_writes_left"}, exp_wa.size(), 0);
    check({tag, "_write_count"}, wd_log.size(), nexp);
    check({tag, "_busy_drops"}, busy_drop, 0);
    if (nexp > 0) check({tag, "_done_after_last_wr"}, dc, last_wr_cyc + 1);
    else          check({tag, "_done_within_7"}, (dc - c0) <= 7, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_en_rd"}, dram_en_rd, 0);
    check({tag, "_en_wr"}, dram_en_wr, 0);
    check({tag, "_addr_in"}, addr_in, 0);
    check({tag, "_addr_out"}, addr_out, 0);
    check({tag, "_data_out"}, data_out, 0);
  endtask

  task automatic check_4x4_literals(input string tag);
    logic [31:0] lit_d[4];
    lit_d[0] = 32'd5; lit_d[1] = 32'd7; lit_d[2] = 32'd13; lit_d[3] = 32'd15;
    check({tag, "_n"}, wd_log.size(), 4);
    for (int i = 0; i < 4 && i < wd_log.size(); i++) begin
      check({tag, "_lit_data"}, wd_log[i], lit_d[i]);
      check({tag, "_lit_addr"}, wa_log[i], OFB + i);
    end
  endtask

  int bad, off;

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    srstn = 1'b1;
    @(negedge clk);

    // 4x4x1 unsigned max over 0..15.
    for (int i = 0; i < 16; i++) mem[IFB + i] = 32'(i);
    run("max4x4", 4, 4, 1, 32'd0, 1'b0);
    check_4x4_literals("max4x4");

    // 2x2x1 {-1,-2,-3,-4} in every mode.
    mem[IFB + 0] = 32'hFFFF_FFFF;
    mem[IFB + 1] = 32'hFFFF_FFFE;
    mem[IFB + 2] = 32'hFFFF_FFFD;
    mem[IFB + 3] = 32'hFFFF_FFFC;
    run("avg_s2x2", 2, 2, 1, 32'd3, 1'b0);
    if (wd_log.size() > 0) check("avg_s2x2_lit", wd_log[0], 32'hFFFF_FFFD);
    else unexpected("avg_s2x2_lit_missing", 0);
    run("max_u2x2", 2, 2, 1, 32'd0, 1'b0);
    if (wd_log.size() > 0) check("max_u2x2_lit", wd_log[0], 32'hFFFF_FFFF);
    else unexpected("max_u2x2_lit_missing", 0);
    run("avg_u2x2", 2, 2, 1, 32'd1, 1'b0);
    run("max_s2x2", 2, 2, 1, 32'd2, 1'b0);

    // Mixed signs: signed max must differ from unsigned max here.
    mem[IFB + 0] = 32'd5;
    mem[IFB + 1] = 32'hFFFF_FFF0;
    mem[IFB + 2] = 32'd5;
    mem[IFB + 3] = 32'd2;
    run("max_s_mix", 2, 2, 1, 32'd2, 1'b0);
    if (wd_log.size() > 0) check("max_s_mix_lit", wd_log[0], 32'd5);
    else unexpected("max_s_mix_lit_missing", 0);

    // 5x3x2 max: odd dims, two planes.
    for (int i = 0; i < 30; i++) mem[IFB + i] = $urandom();
    run("c5x3x2", 5, 3, 2, 32'd0, 1'b0);
    check("c5x3x2_n_lit", wd_log.size(), 4);
    if (rd_log.size() > 12) check("c5x3x2_plane1_start", rd_log[12], 131087);
    else unexpected("c5x3x2_short_reads", rd_log.size());
    bad = 0;
    for (int i = 4; i < rd_log.size(); i++) begin
      off = (int'(rd_log[i]) - IFB) % 15;
      if ((off % 5) == 4 || (off / 5) == 2) bad++;
    end
    check("c5x3x2_edge_never_read", bad, 0);
    run("c5x3x2_smax", 5, 3, 2, 32'd2, 1'b0);

    for (int i = 0; i < 72; i++) mem[IFB + i] = $urandom();
    run("c7x5x2_savg", 7, 5, 2, 32'd3, 1'b0);
    run("c6x4x3_uavg", 6, 4, 3, 32'd1, 1'b0);

    // Degenerate shapes.
    run("w1", 1, 4, 1, 32'd0, 1'b0);
    run("d0", 4, 4, 0, 32'd0, 1'b0);
    run("h1", 4, 1, 2, 32'd0, 1'b0);

    // Reset in the middle of POOL, then rerun.
    for (int i = 0; i < 16; i++) mem[IFB + i] = 32'(i);
    set_params(4, 4, 1, 32'd0);
    build_model(4, 4, 1, 32'd0);
    clear_logs();
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);
    enable = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_in_pool", busy, 1);
    srstn = 1'b0;
    @(negedge clk);
    check_reset_outputs("abort");
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    clear_logs();
    srstn = 1'b1;
    repeat (20) @(negedge clk);
    check("abort_no_writes", wd_log.size(), 0);
    check("abort_idle", busy, 0);
    run("rerun4x4", 4, 4, 1, 32'd0, 1'b0);
    check_4x4_literals("rerun4x4");

    // Enable held high for the whole run.
    for (int i = 0; i < 27; i++) mem[IFB + i] = $urandom();
    run("hold3x3x3", 3, 3, 3, 32'd3, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
